// File: rtl/frame_sequencer.sv
// frame_sequencer: admits exactly one frame into the 3x3 filter pipeline, flushes the
// line buffers with zero lines, counts filtered output beats and pulses done.
// Optional drain watchdog: define FRAME_TIMEOUT_EN.
module frame_sequencer #(
    parameter int IMG_WIDTH      = 512,
    parameter int IMG_HEIGHT     = 512,
    parameter int PAD_LINES      = 2,
    parameter int OUT_LINES      = 512,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done_intr,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              p_valid,
    output logic [DATA_W-1:0] p_data,
    input  logic              p_ready,
    input  logic              q_valid,
    input  logic              q_ready,
    output logic              o_last,
    output logic              o_timeout
);
    localparam int IN_TOTAL  = IMG_WIDTH * IMG_HEIGHT;
    localparam int PAD_TOTAL = IMG_WIDTH * PAD_LINES;
    localparam int OUT_TOTAL = IMG_WIDTH * OUT_LINES;
    localparam int IN_W      = $clog2(IN_TOTAL) + 1;
    localparam int PAD_W     = $clog2(PAD_TOTAL) + 1;
    localparam int OUT_W     = $clog2(OUT_TOTAL) + 1;
    // with PAD_LINES=0 the PAD state is never entered, so the truncated constant is harmless
    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(IN_TOTAL - 1);
    localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(PAD_TOTAL - 1);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(OUT_TOTAL - 1);

    typedef enum logic [2:0] {IDLE, RUN, PAD, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  in_cnt_q, in_cnt_d;
    logic [PAD_W-1:0] pad_cnt_q, pad_cnt_d;
    logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_done_q, out_done_d;
    logic             counting, out_at_last, out_xfer, last_xfer, wd_expire;

    assign counting    = (state_q == RUN) || (state_q == PAD) || (state_q == DRAIN);
    assign out_at_last = out_cnt_q == OUT_LAST;
    assign out_xfer    = counting && q_valid && q_ready && !out_done_q;
    assign last_xfer   = out_xfer && out_at_last;
    assign o_last      = counting && q_valid && out_at_last && !out_done_q;
    assign o_busy      = state_q != IDLE;

    // next state, datapath steering and counter updates; abort overrides everything
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        pad_cnt_d   = pad_cnt_q;
        out_cnt_d   = out_cnt_q;
        out_done_d  = out_done_q;
        s_ready     = 1'b0;
        p_valid     = 1'b0;
        p_data      = '0;
        o_done_intr = 1'b0;
        if (out_xfer) begin
            out_cnt_d  = out_at_last ? out_cnt_q : out_cnt_q + 1'b1;
            out_done_d = out_at_last;
        end
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d    = RUN;
                    in_cnt_d   = '0;
                    pad_cnt_d  = '0;
                    out_cnt_d  = '0;
                    out_done_d = 1'b0;
                end
            end
            RUN: begin
                s_ready = p_ready;
                p_valid = s_valid;
                p_data  = s_data;
                if (s_valid && p_ready) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == IN_LAST) state_d = (PAD_LINES == 0) ? DRAIN : PAD;
                end
            end
            PAD: begin
                p_valid = 1'b1;
                if (p_ready) begin
                    pad_cnt_d = pad_cnt_q + 1'b1;
                    if (pad_cnt_q == PAD_LAST) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_done_q || last_xfer || wd_expire) state_d = DONE;
            end
            DONE: begin
                o_done_intr = !i_abort;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_abort) begin
            state_d    = IDLE;
            in_cnt_d   = '0;
            pad_cnt_d  = '0;
            out_cnt_d  = '0;
            out_done_d = 1'b0;
        end
    end

    // state and counter registers
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q    <= IDLE;
            in_cnt_q   <= '0;
            pad_cnt_q  <= '0;
            out_cnt_q  <= '0;
            out_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            pad_cnt_q  <= pad_cnt_d;
            out_cnt_q  <= out_cnt_d;
            out_done_q <= out_done_d;
        end
    end

`ifdef FRAME_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    assign o_timeout = timeout_q;

    // drain watchdog: counts silent DRAIN cycles, any counted output beat restarts it
    always_comb begin
        wd_cnt_d  = '0;
        timeout_d = timeout_q;
        wd_expire = (state_q == DRAIN) && (wd_cnt_q == WD_LAST);
        if (state_q == DRAIN && !i_abort) wd_cnt_d = out_xfer ? '0 : wd_cnt_q + 1'b1;
        if (state_q == IDLE && i_start && !i_abort) timeout_d = 1'b0;
        if (wd_expire && !out_done_q && !last_xfer && !i_abort) timeout_d = 1'b1;
    end

    // watchdog registers
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign o_timeout = 1'b0;
`endif

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Per-frame controller placed in front of the 3x3 spatial-filter pipeline (line-buffer control, convolution, output FIFO). Under software start/abort control it admits exactly one frame of input pixels into the pipeline. It then injects zero-valued flush lines to drain the line buffers. It counts filtered output beats, flags the last one, and raises a one-cycle done interrupt when the frame is complete.

Parameters:
IMG_WIDTH, 512, pixels per line
IMG_HEIGHT, 512, input lines per frame
PAD_LINES, 2, zero lines injected after the frame to flush line buffers (0 allowed)
OUT_LINES, 512, filtered lines expected from the pipeline per frame
DATA_W, 8, pixel width
TIMEOUT_CYCLES, 65536, drain watchdog limit (used only with the optional feature)

Ports:
axi_clk  in  1  clock
axi_reset_n  in  1  asynchronous active-low reset
i_start  in  1  frame start pulse
i_abort  in  1  abort current frame
o_busy  out  1  high in any state except IDLE
o_done_intr  out  1  one-cycle frame-done pulse
s_valid  in  1  upstream pixel valid
s_data  in  DATA_W  upstream pixel
s_ready  out  1  upstream ready
p_valid  out  1  pixel valid into pipeline
p_data  out  DATA_W  pixel into pipeline
p_ready  in  1  pipeline ready (not prog_full)
q_valid  in  1  pipeline output valid (monitored)
q_ready  in  1  downstream ready on pipeline output (monitored)
o_last  out  1  marks final output beat of the frame
o_timeout  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset: state IDLE, all counters 0, o_busy=0, o_done_intr=0, s_ready=0, p_valid=0, p_data=0, o_last=0, o_timeout=0.
- States: IDLE, RUN, PAD, DRAIN, DONE.
- IDLE: s_ready=0, p_valid=0. i_start=1 moves to RUN on the next cycle and clears in_cnt, pad_cnt, out_cnt and out_done.
- RUN: combinational pass-through: p_valid=s_valid, p_data=s_data, s_ready=p_ready.
  - in_cnt increments on s_valid & p_ready.
  - On the transfer where in_cnt == IMG_WIDTH*IMG_HEIGHT-1, go to PAD, or to DRAIN if PAD_LINES=0.
  - s_ready=0 in every other state, so no pixel beyond the frame is accepted.
- PAD: p_valid=1, p_data=0, s_ready=0. pad_cnt increments on p_ready. On the transfer where pad_cnt == IMG_WIDTH*PAD_LINES-1, go to DRAIN.
- Output counting is active in RUN, PAD and DRAIN.
  - out_cnt increments on q_valid & q_ready.
  - o_last = q_valid & busy & (out_cnt == IMG_WIDTH*OUT_LINES-1) & !out_done. It is combinational.
  - The last transfer sets sticky out_done. out_cnt saturates there; further beats are not counted.
- DRAIN: p_valid=0. If out_done is set, or the last output transfer happens this cycle, go to DONE.
- DONE: o_done_intr=1 for exactly one cycle, then IDLE. Output beats in IDLE/DONE are ignored and o_last=0.
- i_start while busy is ignored.
- i_abort in any state forces IDLE on the next cycle with counters cleared and no done pulse. i_abort has priority over i_start in the same cycle.
- Counter widths are $clog2 of the respective total +1. Comparisons are made against constants computed from the parameters.
- Pipeline latency is not assumed; completion is determined only by out_cnt.
- Reset asserted mid-frame returns to the reset values immediately (asynchronous).

Optional Feature:
FRAME_TIMEOUT_EN:
- Defined: a cycle counter runs in DRAIN and clears on every counted output beat.
- When it reaches TIMEOUT_CYCLES-1, go to DONE (done pulse is still issued) and set o_timeout.
- o_timeout clears on the next accepted i_start or on reset.
- Undefined: no watchdog; o_timeout is tied to 0 and DRAIN waits indefinitely.

Test Plan:
- Basic frame (IMG_WIDTH=4, IMG_HEIGHT=4, PAD_LINES=2, OUT_LINES=4), all ready=1 -> 16 pass-through beats, then 8 zero beats on p_*; o_last on output beat 16; o_done_intr one cycle after it, then o_busy=0.
- Backpressure: p_ready toggles 1010 during RUN/PAD -> exactly 16 s-side transfers and 8 pad transfers; s_ready mirrors p_ready in RUN and is 0 afterwards; pixel order preserved.
- Early/late output: 16 output beats all arrive during PAD -> DRAIN is entered and exits next cycle to DONE. Output held off 100 cycles into DRAIN -> o_busy stays 1 until the 16th beat.
- Abort: i_abort on in-beat 7 -> IDLE next cycle, s_ready=0, no done pulse. A new i_start then counts from 0.
- Start while busy / simultaneous start+abort -> start ignored in both cases; 17th upstream pixel never accepted.
- With FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=32 -> deliver only 10 output beats; o_timeout=1 and o_done_intr after 32 idle DRAIN cycles.
